// File: rtl/multi_channel_event_packetizer.sv
// multi_channel_event_packetizer: N-channel ADC event capture, round-robin arbitration, byte packets to the SD write FIFO
// Define EVENT_CHECKSUM_EN to append an XOR checksum byte to every packet.
module multi_channel_event_packetizer #(
  parameter int NUM_CH = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk210_p,
  input  logic                 reset_p,
  input  logic [NUM_CH-1:0]    adc_valid_p,
  input  logic [16*NUM_CH-1:0] adc_data_p,
  input  logic [15:0]          adc_threshold_p,
  input  logic                 adc_sampling_mode_p,
  input  logic [NUM_CH-1:0]    channel_enable_p,
  input  logic [63:0]          timekeeper_time_p,
  input  logic                 timekeeper_ready_p,
  output logic [7:0]           sd_write_fifo_din_p,
  output logic                 sd_write_fifo_wr_en_p,
  input  logic                 sd_write_fifo_full_p,
  output logic [31:0]          event_count_p,
  output logic [15:0]          drop_count_p,
  output logic                 busy_p
);
`ifdef EVENT_CHECKSUM_EN
  localparam int PKT_BYTES = 13;
`else
  localparam int PKT_BYTES = 12;
`endif
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state, state_n;
  logic [NUM_CH-1:0] pending, qualify, grant_oh, drop_v, accept;
  logic [15:0] hold_sample [NUM_CH];
  logic [63:0] hold_time [NUM_CH];
  logic [CW-1:0] last, grant;
  logic found, take, send, last_byte;
  logic [2:0] buf_ch;
  logic [63:0] buf_time;
  logic [15:0] buf_sample;
  logic [3:0] idx, n_drop;
  logic [16:0] drop_sum;
  logic [95:0] pkt;
  logic [7:0] cur_byte;
  int c;
  always_comb begin
    qualify = '0;
    for (int i = 0; i < NUM_CH; i++)
      qualify[i] = adc_valid_p[i] & channel_enable_p[i] & timekeeper_ready_p &
                   (adc_sampling_mode_p | (adc_data_p[16*i +: 16] >= adc_threshold_p));
  end
  // first pending channel after the last one granted
  always_comb begin
    grant = '0;
    found = 1'b0;
    c = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(last) + k) % NUM_CH;
      if (!found && pending[c]) begin
        grant = CW'(c);
        found = 1'b1;
      end
    end
  end
  assign take     = (state == IDLE) && found;
  assign grant_oh = take ? (NUM_CH'(1) << grant) : '0;
  // a channel granted on this edge has room again, so its new sample is accepted
  assign drop_v   = qualify & pending & ~grant_oh;
  assign accept   = qualify & ~drop_v;
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_CH; i++) n_drop = n_drop + 4'(drop_v[i]);
  end
  assign drop_sum  = {1'b0, drop_count_p} + 17'(n_drop);
  assign send      = (state == SEND) && !sd_write_fifo_full_p;
  assign last_byte = idx == 4'(PKT_BYTES - 1);
  assign pkt       = {SYNC_BYTE, 5'b0, buf_ch, buf_time, buf_sample};
`ifdef EVENT_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int b = 0; b < 12; b++) csum = csum ^ pkt[8*b +: 8];
  end
  assign cur_byte = (idx == 4'd12) ? csum : 8'(pkt >> (8 * (11 - int'(idx))));
`else
  assign cur_byte = 8'(pkt >> (8 * (11 - int'(idx))));
`endif
  always_comb begin
    state_n = (state == IDLE && found) ? LOAD :
              (state == LOAD)          ? SEND :
              (send && last_byte)      ? IDLE : state;
  end
  always_ff @(posedge clk210_p) state <= reset_p ? IDLE : state_n;
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      pending               <= '0;
      last                  <= CW'(NUM_CH - 1);
      idx                   <= '0;
      sd_write_fifo_din_p   <= '0;
      sd_write_fifo_wr_en_p <= 1'b0;
      event_count_p         <= '0;
      drop_count_p          <= '0;
      busy_p                <= 1'b0;
    end else begin
      pending <= (pending & ~grant_oh) | accept;
      for (int i = 0; i < NUM_CH; i++)
        if (accept[i]) begin
          hold_sample[i] <= adc_data_p[16*i +: 16];
          hold_time[i]   <= timekeeper_time_p;
        end
      if (take) begin
        last       <= grant;
        buf_ch     <= 3'(grant);
        buf_time   <= hold_time[grant];
        buf_sample <= hold_sample[grant];
      end
      idx                   <= (state == LOAD) ? 4'd0 : send ? idx + 4'd1 : idx;
      sd_write_fifo_wr_en_p <= send;
      if (send) sd_write_fifo_din_p <= cur_byte;
      if (send && last_byte) event_count_p <= event_count_p + 32'd1;
      drop_count_p <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      busy_p       <= state_n != IDLE;
    end
  end
endmodule
